// File: rtl/breakout_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// breakout_pkg -- hit codes, display defaults and ball FSM states shared by
// the breakout blocks.                                        Revision: 1.0
// ----------------------------------------------------------------------------
package breakout_pkg;

  localparam logic [1:0] HIT_NONE   = 2'b00;
  localparam logic [1:0] HIT_VERT   = 2'b01;
  localparam logic [1:0] HIT_HORZ   = 2'b10;
  localparam logic [1:0] HIT_CORNER = 2'b11;

  localparam int DEF_D_WIDTH  = 640;
  localparam int DEF_D_HEIGHT = 480;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_ACK  = 3'd2,
    ST_LOST = 3'd3,
    ST_OVER = 3'd4
  } ball_state_e;

endpackage
`default_nettype wire

// File: rtl/hit_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hit_arbiter -- folds the per-block hit slots into one combined code, a
// count of reporting blocks and an any-hit flag.              Revision: 1.0
// ----------------------------------------------------------------------------
module hit_arbiter
  import breakout_pkg::*;
#(
  parameter int N_BLOCKS = 8,
  parameter int CNT_W    = $clog2(N_BLOCKS + 1)
) (
  input  logic [2*N_BLOCKS-1:0] i_hit,
  output logic [1:0]            o_code,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_any
);

  logic [1:0]          w_slot [N_BLOCKS];
  logic [N_BLOCKS-1:0] w_nz;

  for (genvar k = 0; k < N_BLOCKS; k++) begin : g_slot
    assign w_slot[k] = i_hit[2*k +: 2];
    assign w_nz[k]   = (w_slot[k] != HIT_NONE);
  end

  always_comb begin
    o_code  = HIT_NONE;
    o_count = '0;
    for (int k = 0; k < N_BLOCKS; k++) begin
      o_code  = o_code | w_slot[k];
      o_count = o_count + CNT_W'(w_nz[k]);
    end
  end

  assign o_any = |w_nz;

endmodule
`default_nettype wire

// File: rtl/ball_motion.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ball_motion -- breakout ball FSM: serve, motion, wall/paddle/block bounce,
// score, lives. Define BALL_LIVES_EN for three lives.         Revision: 1.0
// ----------------------------------------------------------------------------
module ball_motion
  import breakout_pkg::*;
#(
  parameter int S_SIZE   = 10,
  parameter int IX       = 320,
  parameter int IY       = 400,
  parameter int D_WIDTH  = DEF_D_WIDTH,
  parameter int D_HEIGHT = DEF_D_HEIGHT,
  parameter int N_BLOCKS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ani_stb,
  input  logic                  i_animate,
  input  logic                  i_start,
  input  logic [11:0]           i_x1,
  input  logic [11:0]           i_x2,
  input  logic [11:0]           i_py1,
  input  logic [2*N_BLOCKS-1:0] i_hit,
  output logic [11:0]           o_x,
  output logic [11:0]           o_y,
  output logic [11:0]           o_x1,
  output logic [11:0]           o_x2,
  output logic [11:0]           o_y1,
  output logic [11:0]           o_y2,
  output logic                  o_col_detected,
  output logic [8:0]            o_score,
  output logic [1:0]            o_lives,
  output logic                  o_endgame
);

  localparam int          CNT_W    = $clog2(N_BLOCKS + 1);
  localparam logic [11:0] c_size   = 12'(S_SIZE);
  localparam logic [12:0] c_size13 = 13'(S_SIZE);
  localparam logic [11:0] c_ix     = 12'(IX);
  localparam logic [11:0] c_iy     = 12'(IY);
  localparam logic [11:0] c_xmax   = 12'(D_WIDTH - S_SIZE - 1);
  localparam logic [11:0] c_ymiss  = 12'(D_HEIGHT - S_SIZE);
  localparam logic [8:0]  c_win    = 9'(N_BLOCKS);

  // Direction flags: 1 means +1 pixel per strobe, 0 means -1.
  ball_state_e state_q, state_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic [8:0]  score_q, score_d;
  logic        col_q, col_d;

  logic [1:0]       w_code;
  logic [CNT_W-1:0] w_count;
  logic             w_any;
  logic             w_step;
  logic             w_miss;
  logic             w_paddle;
  logic [9:0]       w_score_sum;

  hit_arbiter #(
    .N_BLOCKS (N_BLOCKS),
    .CNT_W    (CNT_W)
  ) u_hit_arbiter (
    .i_hit   (i_hit),
    .o_code  (w_code),
    .o_count (w_count),
    .o_any   (w_any)
  );

  assign w_step      = i_ani_stb & i_animate;
  assign w_miss      = (y_q >= c_ymiss);
  assign w_paddle    = dy_q && (({1'b0, y_q} + c_size13) == {1'b0, i_py1}) &&
                       (x_q >= i_x1) && (x_q <= i_x2);
  assign w_score_sum = {1'b0, score_q} + 10'(w_count);

`ifdef BALL_LIVES_EN
  logic [1:0] lives_q, lives_d;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    score_d = score_q;
`ifdef BALL_LIVES_EN
    lives_d = lives_q;
`endif
    // Clearing the board overrides every other transition and freezes the ball.
    if ((state_q != ST_OVER) && (score_q >= c_win)) begin
      state_d = ST_OVER;
    end else begin
      case (state_q)
        ST_IDLE: begin
          x_d  = c_ix;
          y_d  = c_iy;
          dx_d = 1'b1;
          dy_d = 1'b0;
          if (i_start) state_d = ST_RUN;
        end
        ST_RUN, ST_ACK: begin
          if (w_miss) begin
            state_d = ST_LOST;
          end else begin
            if ((state_q == ST_RUN) && w_any) begin
              if ((w_code & HIT_VERT) != HIT_NONE) dy_d = ~dy_q;
              if ((w_code & HIT_HORZ) != HIT_NONE) dx_d = ~dx_q;
              score_d = (w_score_sum > 10'd511) ? 9'd511 : w_score_sum[8:0];
              state_d = ST_ACK;
            end else if ((state_q == ST_ACK) && !w_any) begin
              state_d = ST_RUN;
            end
            // Walls are applied after block reflection so their absolute
            // direction wins; the move uses the freshly resolved direction.
            if (w_step) begin
              if (w_paddle)         dy_d = 1'b0;
              if (x_q <= c_size)    dx_d = 1'b1;
              if (x_q >= c_xmax)    dx_d = 1'b0;
              if (y_q <= c_size)    dy_d = 1'b1;
              x_d = dx_d ? (x_q + 12'd1) : (x_q - 12'd1);
              y_d = dy_d ? (y_q + 12'd1) : (y_q - 12'd1);
            end
          end
        end
        ST_LOST: begin
`ifdef BALL_LIVES_EN
          lives_d = lives_q - 2'd1;
          if (lives_q == 2'd1) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_IDLE;
            x_d     = c_ix;
            y_d     = c_iy;
            dx_d    = 1'b1;
            dy_d    = 1'b0;
          end
`else
          state_d = ST_OVER;
`endif
        end
        ST_OVER: begin
          state_d = ST_OVER;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    col_d = (state_d == ST_ACK);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      x_q     <= c_ix;
      y_q     <= c_iy;
      dx_q    <= 1'b1;
      dy_q    <= 1'b0;
      score_q <= '0;
      col_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      score_q <= score_d;
      col_q   <= col_d;
    end
  end

`ifdef BALL_LIVES_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) lives_q <= 2'd3;
    else       lives_q <= lives_d;
  end
  assign o_lives = lives_q;
`else
  assign o_lives = 2'd1;
`endif

  assign o_x            = x_q;
  assign o_y            = y_q;
  assign o_x1           = x_q - c_size;
  assign o_x2           = x_q + c_size;
  assign o_y1           = y_q - c_size;
  assign o_y2           = y_q + c_size;
  assign o_col_detected = col_q;
  assign o_score        = score_q;
  assign o_endgame      = (state_q == ST_OVER);

endmodule
`default_nettype wire

// File: tb/tb_ball_motion.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ball_motion -- directed scenarios plus randomized play against a
// cycle-level behavioural model of the ball.                  Revision: 1.0
// ----------------------------------------------------------------------------
module tb_ball_motion;

  localparam int S  = 10;
  localparam int IX = 320;
  localparam int IY = 400;
  localparam int W  = 640;
  localparam int H  = 480;
  localparam int NB = 8;
`ifdef BALL_LIVES_EN
  localparam int LIVES0    = 3;
  localparam int LIVES_DEC = 1;
`else
  localparam int LIVES0    = 1;
  localparam int LIVES_DEC = 0;
`endif
  localparam int M_IDLE = 0, M_PLAY = 1, M_ACK = 2, M_LOST = 3, M_OVER = 4;

  logic            clk = 1'b0;
  logic            rst, stb, animate, start;
  logic [11:0]     px1, px2, py1;
  logic [2*NB-1:0] hit;
  logic [11:0]     x, y, x1, x2, y1, y2;
  logic            col, endgame;
  logic [8:0]      score;
  logic [1:0]      lives;

  ball_motion #(
    .S_SIZE(S), .IX(IX), .IY(IY), .D_WIDTH(W), .D_HEIGHT(H), .N_BLOCKS(NB)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_animate(animate),
    .i_start(start), .i_x1(px1), .i_x2(px2), .i_py1(py1), .i_hit(hit),
    .o_x(x), .o_y(y), .o_x1(x1), .o_x2(x2), .o_y1(y1), .o_y2(y2),
    .o_col_detected(col), .o_score(score), .o_lives(lives), .o_endgame(endgame)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int m_st, m_x, m_y, m_dx, m_dy, m_score, m_lives;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic serve();
    m_x = IX; m_y = IY; m_dx = 1; m_dy = -1;
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic model_step();
    int code, cnt, ndx, ndy, s;
    code = 0; cnt = 0;
    for (int k = 0; k < NB; k++) begin
      s = int'((hit >> (2*k)) & 16'h3);
      if (s != 0) begin
        code = code | s;
        cnt++;
      end
    end
    if (rst) begin
      m_st = M_IDLE; serve(); m_score = 0; m_lives = LIVES0;
      return;
    end
    if (m_st != M_OVER && m_score >= NB) begin
      m_st = M_OVER;
      return;
    end
    case (m_st)
      M_IDLE: begin
        serve();
        if (start) m_st = M_PLAY;
      end
      M_LOST: begin
        m_lives = m_lives - LIVES_DEC;
        if (LIVES_DEC == 0 || m_lives == 0) m_st = M_OVER;
        else begin
          m_st = M_IDLE;
          serve();
        end
      end
      M_PLAY, M_ACK: begin
        if (m_y >= H - S) m_st = M_LOST;
        else begin
          ndx = m_dx; ndy = m_dy;
          if (m_st == M_PLAY && cnt > 0) begin
            if ((code & 1) != 0) ndy = -ndy;
            if ((code & 2) != 0) ndx = -ndx;
            m_score = (m_score + cnt > 511) ? 511 : m_score + cnt;
            m_st = M_ACK;
          end else if (m_st == M_ACK && cnt == 0) begin
            m_st = M_PLAY;
          end
          if (stb && animate) begin
            if (m_dy == 1 && m_y + S == py1 && m_x >= px1 && m_x <= px2) ndy = -1;
            if (m_x <= S)         ndx = 1;
            if (m_x >= W - S - 1) ndx = -1;
            if (m_y <= S)         ndy = 1;
            m_x = (m_x + ndx) & 4095;
            m_y = (m_y + ndy) & 4095;
          end
          m_dx = ndx; m_dy = ndy;
        end
      end
      default: ;
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("x", x, m_x);
    check("y", y, m_y);
    check("x1", x1, (m_x - S) & 4095);
    check("y2", y2, (m_y + S) & 4095);
    check("col", col, (m_st == M_ACK));
    check("score", score, m_score);
    check("lives", lives, m_lives);
    check("endgame", endgame, (m_st == M_OVER));
  endtask

  task automatic do_reset();
    rst = 1; hit = '0; start = 0; stb = 0;
    cycle();
    rst = 0;
  endtask

  task automatic serve_start();
    start = 1;
    cycle();
    start = 0;
  endtask

  task automatic strobes(input int n);
    stb = 1;
    repeat (n) cycle();
    stb = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; stb = 0; animate = 1; start = 0;
    px1 = '0; px2 = '0; py1 = '0; hit = '0;
    cycle();
    rst = 0;
    check("rst_x", x, IX);
    check("rst_y", y, IY);
    check("rst_x2", x2, IX + S);
    check("rst_y1", y1, IY - S);
    check("rst_score", score, 0);
    check("rst_lives", lives, LIVES0);
    check("rst_col", col, 0);
    check("rst_endgame", endgame, 0);

    // Serve and five strobes, then run into the right wall.
    serve_start();
    strobes(5);
    check("serve_x", x, 325);
    check("serve_y", y, 395);
    check("serve_score", score, 0);
    for (int i = 0; i < 400 && x != 629; i++) strobes(1);
    check("wall_at", x, 629);
    strobes(1);
    check("wall_turn", x, 628);
    strobes(1);
    check("wall_next", x, 627);

    // Vertical hit on slot 2 held three cycles.
    do_reset();
    serve_start();
    strobes(3);
    hit = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("ack_col_hi", col, 1);
    end
    check("ack_score", score, 1);
    hit = '0;
    cycle();
    check("ack_col_lo", col, 0);
    strobes(1);
    check("vflip_y", y, 398);
    check("vflip_x", x, 324);

    // Corner hits on slots 0 and 5; a later hit during ACK is ignored.
    do_reset();
    serve_start();
    strobes(2);
    hit = 16'h0C03;
    cycle();
    check("corner_score", score, 2);
    hit = 16'h0008;
    cycle();
    check("ack_ignore_score", score, 2);
    check("ack_ignore_col", col, 1);
    hit = '0;
    cycle();
    check("corner_col_lo", col, 0);
    strobes(1);
    check("corner_x", x, 321);
    check("corner_y", y, 399);

    // Reset in the middle of an ACK.
    do_reset();
    serve_start();
    hit = 16'h0004;
    cycle();
    check("pre_rst_col", col, 1);
    rst = 1;
    cycle();
    rst = 0;
    check("mid_rst_col", col, 0);
    check("mid_rst_score", score, 0);
    hit = '0;
    strobes(1);
    check("mid_rst_idle_x", x, IX);

    // Clearing all blocks ends the game and freezes the ball.
    do_reset();
    serve_start();
    hit = 16'h5555;
    cycle();
    check("win_score", score, 8);
    hit = '0;
    cycle();
    check("win_endgame", endgame, 1);
    check("win_col", col, 0);
    start = 1;
    strobes(2);
    start = 0;
    check("win_frozen_x", x, IX);
    check("win_still_over", endgame, 1);

    // Miss the paddle until the lives run out.
    do_reset();
    py1 = '0; px1 = '0; px2 = '0;
    for (int r = 0; r < LIVES0; r++) begin
      serve_start();
      hit = 16'h0001;
      cycle();
      hit = '0;
      cycle();
      for (int i = 0; i < 200 && y < 470; i++) strobes(1);
      check("miss_y", y, 470);
      cycle();
      cycle();
      check("miss_lives", lives, LIVES0 - LIVES_DEC * (r + 1));
      if (r < LIVES0 - 1) begin
        check("reserve_x", x, IX);
        check("reserve_y", y, IY);
      end
    end
    check("miss_endgame", endgame, 1);

    // Randomized play against the model.
    for (int ep = 0; ep < 20; ep++) begin
      do_reset();
      py1 = 12'($urandom_range(380, 470));
      px1 = 12'($urandom_range(0, 400));
      px2 = px1 + 12'($urandom_range(0, 240));
      for (int c = 0; c < 2000; c++) begin
        stb     = ($urandom_range(0, 3) != 0);
        animate = ($urandom_range(0, 7) != 0);
        start   = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 59) == 0) hit = 16'($urandom & $urandom & $urandom);
        else if ($urandom_range(0, 2) == 0) hit = '0;
        rst = ($urandom_range(0, 1999) == 0);
        cycle();
      end
      rst = 0; stb = 0; start = 0; hit = '0; animate = 1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
